branch_target_cam: RTL and testbench

- Reverse of the branch-target lookup table: a writable table of up to 32 branch targets with a sequential search engine.
- Given a 10-bit PC target, it returns the 5-bit table index that holds it, for the assembler/loader path.
- Also provides the forward index-to-target read, so the fetch stage can use it in place of the hardwired table.
- Sits beside the program counter logic; loaded per program at boot by the loader.

---
 rtl/branch_target_cam_if.sv | 29 ++
 rtl/branch_target_cam.sv | 107 ++++++++++
 tb/tb_branch_target_cam.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_target_cam_if.sv
// Bus bundle for branch_target_cam: table write/clear, forward read and the
// reverse-search request/result handshake.
interface branch_target_cam_if #(
    parameter int ADDR_W = 5,
    parameter int TGT_W  = 10
);
    logic              WrEn;
    logic [ADDR_W-1:0] WrAddr;
    logic [TGT_W-1:0]  WrTarget;
    logic              ClrAll;
    logic [ADDR_W-1:0] RdAddr;
    logic [TGT_W-1:0]  RdTarget;
    logic              Req;
    logic [TGT_W-1:0]  ReqTarget;
    logic              Ready;
    logic              Done;
    logic              Hit;
    logic [ADDR_W-1:0] Index;

    modport master (
        output WrEn, WrAddr, WrTarget, ClrAll, RdAddr, Req, ReqTarget,
        input  RdTarget, Ready, Done, Hit, Index
    );

    modport slave (
        input  WrEn, WrAddr, WrTarget, ClrAll, RdAddr, Req, ReqTarget,
        output RdTarget, Ready, Done, Hit, Index
    );
endinterface

// File: rtl/branch_target_cam.sv
// Writable branch-target table with a combinational forward read and a
// sequential, lowest-index-first reverse search engine.
module branch_target_cam #(
    parameter int ADDR_W = 5,
    parameter int TGT_W  = 10
) (
    input logic             Clk,
    input logic             Reset,
    branch_target_cam_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_DONE} state_t;

    state_t            state_q, state_d;
    logic [TGT_W-1:0]  tgt_q   [DEPTH];
    logic [TGT_W-1:0]  tgt_d   [DEPTH];
    logic              valid_q [DEPTH];
    logic              valid_d [DEPTH];
    logic [TGT_W-1:0]  key_q, key_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              hit_q, hit_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic              match;

    // ClrAll takes priority over a same-cycle write, so the write is dropped.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_comb begin
            tgt_d[gi]   = tgt_q[gi];
            valid_d[gi] = valid_q[gi];
            if (bus.ClrAll) begin
                valid_d[gi] = 1'b0;
            end else if (bus.WrEn && (bus.WrAddr == ADDR_W'(gi))) begin
                tgt_d[gi]   = bus.WrTarget;
                valid_d[gi] = 1'b1;
            end
        end

        always_ff @(posedge Clk) begin
            if (Reset) begin
                tgt_q[gi]   <= '0;
                valid_q[gi] <= 1'b0;
            end else begin
                tgt_q[gi]   <= tgt_d[gi];
                valid_q[gi] <= valid_d[gi];
            end
        end
    end

    assign bus.RdTarget = valid_q[bus.RdAddr] ? tgt_q[bus.RdAddr] : '0;

    // Compare sees the table as it was before this edge; a same-cycle write is missed.
    assign match = valid_q[ptr_q] && (tgt_q[ptr_q] == key_q);

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        ptr_d   = ptr_q;
        hit_d   = hit_q;
        index_d = index_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.Req) begin
                    key_d   = bus.ReqTarget;
                    ptr_d   = '0;
                    state_d = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (match) begin
                    index_d = ptr_q;
                    hit_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    index_d = '0;
                    hit_d   = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            ptr_q   <= '0;
            hit_q   <= 1'b0;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            ptr_q   <= ptr_d;
            hit_q   <= hit_d;
            index_q <= index_d;
        end
    end

    assign bus.Ready = (state_q == ST_IDLE);
    assign bus.Done  = (state_q == ST_DONE);
    assign bus.Hit   = hit_q;
    assign bus.Index = index_q;
endmodule

// File: tb/tb_branch_target_cam.sv
// Scenario bench for branch_target_cam: expected search results go into a
// scoreboard queue at request time and are popped when Done is observed.
module tb_branch_target_cam;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_target_cam_if #(.ADDR_W(5), .TGT_W(10)) bus ();

    branch_target_cam #(.ADDR_W(5), .TGT_W(10)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    typedef struct {
        int         cyc;
        logic       hit;
        logic [4:0] idx;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic load(input logic [4:0] a, input logic [9:0] t);
        @(negedge clk);
        bus.WrEn = 1'b1; bus.WrAddr = a; bus.WrTarget = t;
        @(negedge clk);
        bus.WrEn = 1'b0;
    endtask

    task automatic load_table();
        load(5'd0, 10'h040); load(5'd1, 10'h03D); load(5'd2, 10'h034);
        load(5'd3, 10'h053); load(5'd4, 10'h053); load(5'd5, 10'h053);
        load(5'd6, 10'h04A); load(5'd7, 10'h065);
    endtask

    // Drives one search for 40 cycles and reports what the DUT did; no checking here.
    task automatic run_search(input logic [9:0] tgt,
                              input int req_cyc, input logic [9:0] req_tgt,
                              input int wr_cyc, input logic [4:0] wr_addr,
                              input logic [9:0] wr_tgt,
                              output int done_cyc, output int done_cnt,
                              output logic hit, output logic [4:0] idx,
                              output logic ready_after);
        done_cyc = -1; done_cnt = 0; hit = 1'b0; idx = '0; ready_after = 1'b0;
        @(negedge clk);
        bus.Req = 1'b1; bus.ReqTarget = tgt;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            bus.Req = 1'b0; bus.WrEn = 1'b0;
            if (bus.Done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c; hit = bus.Hit; idx = bus.Index;
                end
            end
            if (done_cyc >= 0 && c == done_cyc + 1) ready_after = bus.Ready;
            if (c == req_cyc) begin bus.Req = 1'b1; bus.ReqTarget = req_tgt; end
            if (c == wr_cyc) begin
                bus.WrEn = 1'b1; bus.WrAddr = wr_addr; bus.WrTarget = wr_tgt;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.RdAddr = 5'd3;
        @(negedge clk);
        n_cmp++;
        if ({bus.Ready, bus.Done, bus.Hit, bus.Index} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
            n_bad++;
            $display("FAIL reset_outputs: got rdy/done/hit/idx=%b/%b/%b/%0d want 1/0/0/0",
                     bus.Ready, bus.Done, bus.Hit, bus.Index);
        end
        n_cmp++;
        if (bus.RdTarget !== 10'h000) begin
            n_bad++;
            $display("FAIL reset_rdtarget: got %h want 000", bus.RdTarget);
        end
        $display("reset: rdy=%b rdtarget[3]=%h", bus.Ready, bus.RdTarget);
    endtask

    task automatic test_empty_miss();
        int dc, cnt; logic h, rdy; logic [4:0] ix; exp_t e;
        sb_q.push_back('{cyc: 33, hit: 1'b0, idx: 5'd0});
        run_search(10'h040, -1, '0, -1, '0, '0, dc, cnt, h, ix, rdy);
        e = sb_q.pop_front();
        n_cmp++;
        if (dc !== e.cyc || h !== e.hit || ix !== e.idx) begin
            n_bad++;
            $display("FAIL empty_miss: got cyc=%0d hit=%b idx=%0d want cyc=%0d hit=%b idx=%0d",
                     dc, h, ix, e.cyc, e.hit, e.idx);
        end
        n_cmp++;
        if (rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL empty_ready_after: got %b want 1", rdy);
        end
        $display("search 040 (empty): done_cyc=%0d hit=%b idx=%0d ready_next=%b", dc, h, ix, rdy);
    endtask

    task automatic test_load_search();
        logic [9:0] tg [3] = '{10'h053, 10'h065, 10'h040};
        int         cy [3] = '{5, 9, 2};
        logic [4:0] ixs[3] = '{5'd3, 5'd7, 5'd0};
        int dc, cnt; logic h, rdy; logic [4:0] ix; exp_t e;
        load_table();
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back('{cyc: cy[i], hit: 1'b1, idx: ixs[i]});
            run_search(tg[i], -1, '0, -1, '0, '0, dc, cnt, h, ix, rdy);
            e = sb_q.pop_front();
            n_cmp++;
            if (dc !== e.cyc || h !== e.hit || ix !== e.idx || cnt !== 1) begin
                n_bad++;
                $display("FAIL search_%h: got cyc=%0d hit=%b idx=%0d n=%0d want cyc=%0d hit=%b idx=%0d n=1",
                         tg[i], dc, h, ix, cnt, e.cyc, e.hit, e.idx);
            end
            $display("search %h: done_cyc=%0d hit=%b idx=%0d", tg[i], dc, h, ix);
        end
    endtask

    task automatic test_forward_read();
        @(negedge clk);
        bus.RdAddr = 5'd6;
        #1;
        n_cmp++;
        if (bus.RdTarget !== 10'h04A) begin
            n_bad++;
            $display("FAIL fwd_read_6: got %h want 04a", bus.RdTarget);
        end
        $display("read [6]=%h", bus.RdTarget);
        bus.RdAddr = 5'd8;
        #1;
        n_cmp++;
        if (bus.RdTarget !== 10'h000) begin
            n_bad++;
            $display("FAIL fwd_read_8: got %h want 000", bus.RdTarget);
        end
        $display("read [8]=%h", bus.RdTarget);
    endtask

    task automatic test_req_ignored();
        int dc, cnt; logic h, rdy; logic [4:0] ix; exp_t e;
        sb_q.push_back('{cyc: 9, hit: 1'b1, idx: 5'd7});
        run_search(10'h065, 3, 10'h034, -1, '0, '0, dc, cnt, h, ix, rdy);
        e = sb_q.pop_front();
        n_cmp++;
        if (dc !== e.cyc || h !== e.hit || ix !== e.idx || cnt !== 1) begin
            n_bad++;
            $display("FAIL busy_req: got cyc=%0d hit=%b idx=%0d n=%0d want cyc=%0d hit=%b idx=%0d n=1",
                     dc, h, ix, cnt, e.cyc, e.hit, e.idx);
        end
        $display("search 065 + busy req 034: done_cyc=%0d idx=%0d dones=%0d", dc, ix, cnt);
    endtask

    task automatic test_write_during_search();
        logic [9:0] tg [3] = '{10'h1FF, 10'h1FF, 10'h1AA};
        int         wc [3] = '{2, -1, 5};
        logic [4:0] wa [3] = '{5'd1, 5'd0, 5'd20};
        logic [9:0] wt [3] = '{10'h1FF, 10'h000, 10'h1AA};
        int dc, cnt; logic h, rdy; logic [4:0] ix; exp_t e;
        sb_q.push_back('{cyc: 33, hit: 1'b0, idx: 5'd0});
        sb_q.push_back('{cyc: 3,  hit: 1'b1, idx: 5'd1});
        sb_q.push_back('{cyc: 22, hit: 1'b1, idx: 5'd20});
        for (int i = 0; i < 3; i++) begin
            run_search(tg[i], -1, '0, wc[i], wa[i], wt[i], dc, cnt, h, ix, rdy);
            e = sb_q.pop_front();
            n_cmp++;
            if (dc !== e.cyc || h !== e.hit || ix !== e.idx) begin
                n_bad++;
                $display("FAIL wr_during_search_%0d: got cyc=%0d hit=%b idx=%0d want cyc=%0d hit=%b idx=%0d",
                         i, dc, h, ix, e.cyc, e.hit, e.idx);
            end
            $display("search %h wr@%0d [%0d]: done_cyc=%0d hit=%b idx=%0d", tg[i], wc[i], wa[i], dc, h, ix);
        end
    endtask

    task automatic test_clr_wins();
        int dc, cnt; logic h, rdy; logic [4:0] ix; exp_t e;
        @(negedge clk);
        bus.ClrAll = 1'b1; bus.WrEn = 1'b1; bus.WrAddr = 5'd0; bus.WrTarget = 10'h040;
        @(negedge clk);
        bus.ClrAll = 1'b0; bus.WrEn = 1'b0;
        sb_q.push_back('{cyc: 33, hit: 1'b0, idx: 5'd0});
        run_search(10'h040, -1, '0, -1, '0, '0, dc, cnt, h, ix, rdy);
        e = sb_q.pop_front();
        n_cmp++;
        if (dc !== e.cyc || h !== e.hit || ix !== e.idx) begin
            n_bad++;
            $display("FAIL clr_wins_search: got cyc=%0d hit=%b idx=%0d want cyc=%0d hit=%b idx=%0d",
                     dc, h, ix, e.cyc, e.hit, e.idx);
        end
        bus.RdAddr = 5'd0;
        #1;
        n_cmp++;
        if (bus.RdTarget !== 10'h000) begin
            n_bad++;
            $display("FAIL clr_wins_read: got %h want 000", bus.RdTarget);
        end
        $display("clr+wr then search 040: hit=%b read[0]=%h", h, bus.RdTarget);
    endtask

    task automatic test_reset_mid_search();
        int dc, cnt, ndone; logic h, rdy; logic [4:0] ix; exp_t e;
        load_table();
        sb_q.push_back('{cyc: 9, hit: 1'b1, idx: 5'd7});
        run_search(10'h065, -1, '0, -1, '0, '0, dc, cnt, h, ix, rdy);
        e = sb_q.pop_front();
        n_cmp++;
        if (dc !== e.cyc || h !== e.hit || ix !== e.idx) begin
            n_bad++;
            $display("FAIL pre_reset_search: got cyc=%0d hit=%b idx=%0d want cyc=%0d hit=%b idx=%0d",
                     dc, h, ix, e.cyc, e.hit, e.idx);
        end
        ndone = 0;
        @(negedge clk);
        bus.Req = 1'b1; bus.ReqTarget = 10'h065;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            bus.Req = 1'b0;
            if (bus.Done) ndone++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({bus.Ready, bus.Done, bus.Hit, bus.Index} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: got rdy/done/hit/idx=%b/%b/%b/%0d want 1/0/0/0",
                     bus.Ready, bus.Done, bus.Hit, bus.Index);
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.Done) ndone++;
        end
        n_cmp++;
        if (ndone !== 0) begin
            n_bad++;
            $display("FAIL aborted_done: got %0d pulses want 0", ndone);
        end
        sb_q.push_back('{cyc: 33, hit: 1'b0, idx: 5'd0});
        run_search(10'h065, -1, '0, -1, '0, '0, dc, cnt, h, ix, rdy);
        e = sb_q.pop_front();
        n_cmp++;
        if (dc !== e.cyc || h !== e.hit || ix !== e.idx) begin
            n_bad++;
            $display("FAIL post_reset_search: got cyc=%0d hit=%b idx=%0d want cyc=%0d hit=%b idx=%0d",
                     dc, h, ix, e.cyc, e.hit, e.idx);
        end
        $display("reset mid-search: aborted dones=%0d, re-search 065 done_cyc=%0d hit=%b", ndone, dc, h);
    endtask

    initial begin
        bus.WrEn = 1'b0; bus.WrAddr = '0; bus.WrTarget = '0; bus.ClrAll = 1'b0;
        bus.RdAddr = '0; bus.Req = 1'b0; bus.ReqTarget = '0;
        test_reset();
        test_empty_miss();
        test_load_search();
        test_forward_read();
        test_req_ignored();
        test_write_during_search();
        test_clr_wins();
        test_reset_mid_search();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
